seq_div_unit: RTL and testbench
===============================

Name: seq_div_unit

Overview:
- Multi-cycle unsigned restoring divider; the inverse of the ripple-adder-based mantissa multiply datapath.
- Produces quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Used by the FP divide path for mantissa division; exponent handling lives outside this block.
- Input handshake is valid/ready. The result is held under a valid/ready handshake until the consumer accepts it.

Parameters:
- WIDTH, 24, operand/quotient/remainder width (mantissa incl. hidden bit); legal range 2..32.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_dividend  input  WIDTH  dividend N.
- i_divisor  input  WIDTH  divisor D.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_quotient  output  WIDTH  floor(N/D).
- o_remainder  output  WIDTH  N mod D.
- o_div_zero  output  1  D was zero for this result.
- o_sticky  output  1  present only with DIV_STICKY_EN; remainder non-zero.

Behaviour:
- Reset (async, i_rst_n=0):
  - State goes to IDLE.
  - o_valid=0, o_quotient=0, o_remainder=0, o_div_zero=0, o_sticky=0.
  - Internal counter and partial remainder are cleared.
  - o_ready=1 from the first cycle after release.
- States are IDLE, CALC, DONE. o_ready = (state==IDLE); it is combinational from state only.
- Accept: at a rising edge with i_valid & o_ready, N and D are registered. Later input changes are ignored until the next accept.
  - D!=0: go to CALC, count=0, partial remainder P=0 (WIDTH+1 bits), quotient register Q=N.
  - D==0: go straight to DONE with Q=all ones, remainder=N, o_div_zero=1.
- CALC, one iteration per edge:
  - {P,Q} shift left 1; P takes Q's MSB.
  - T = P - {1'b0,D} (WIDTH+1 bits).
  - If T non-negative: P=T and Q LSB=1; else Q LSB=0.
  - count increments. On the edge where count==WIDTH-1, go to DONE.
- Latency: o_valid rises WIDTH edges after the accept edge for D!=0, and 1 edge after for D==0.
- DONE:
  - o_valid=1; o_quotient=Q, o_remainder=P[WIDTH-1:0], o_div_zero as computed.
  - All outputs stay stable while i_ready=0, for any number of cycles.
  - At the edge with o_valid & i_ready, go to IDLE and drop o_valid.
  - o_quotient, o_remainder and o_div_zero hold their last values in IDLE and clear only on reset or new results.
- No accept is possible in CALC or DONE: i_valid is ignored there and the upstream source must hold it.
- Throughput is at best one operation per WIDTH+2 cycles.
- Boundaries:
  - N=0 gives Q=0, R=0 after the full WIDTH cycles; there is no early exit.
  - N<D gives Q=0, R=N.
  - D=1 gives Q=N, R=0.
  - Reset asserted in CALC or DONE aborts immediately; the result is discarded.
  - i_ready held high before DONE has no effect.

Optional Feature:
- DIV_STICKY_EN defined:
  - o_sticky port exists; o_sticky = |remainder, registered with the other outputs in DONE.
  - o_sticky=0 for the div-by-zero case.
  - It feeds round/sticky logic of the FP divide path.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=24, N=100, D=7, i_ready=1 -> o_valid exactly 24 cycles after accept, o_quotient=14, o_remainder=2, o_div_zero=0, o_ready=1 again one cycle after result handshake.
- N=0xFFFFFF, D=1 -> o_quotient=0xFFFFFF, o_remainder=0; then N=5, D=9 -> quotient 0, remainder 5.
- N=5, D=0 -> o_valid one cycle after accept, o_div_zero=1, o_quotient=0xFFFFFF, o_remainder=5; next op 100/7 shows o_div_zero=0.
- N=0xC00000, D=0x800000, i_ready held 0 for 10 cycles after o_valid -> outputs constant (q=1, r=0x400000, o_sticky=1 with DIV_STICKY_EN), o_ready=0, new i_valid ignored; release i_ready -> one handshake, then IDLE.
- Accept 100/7, assert i_rst_n=0 at 10th CALC cycle -> all outputs 0 immediately, o_ready=1 after release; a new 49/7 op yields q=7, r=0, o_sticky=0.
- Change i_dividend/i_divisor every cycle during CALC -> result matches operands captured at the accept edge.

Source files
------------

// File: rtl/seq_div_unit_if.sv
// Handshake bundle for seq_div_unit.
//   slave  : divider side (accepts operands, produces result)
//   master : producer/consumer side (drives operands, accepts result)
// Signals:
//   i_valid/o_ready                operand handshake
//   i_dividend/i_divisor           WIDTH-bit operands N and D
//   o_valid/i_ready                result handshake
//   o_quotient/o_remainder         WIDTH-bit floor(N/D) and N mod D
//   o_div_zero                     D was zero for this result
//   o_sticky                       remainder non-zero (only with DIV_STICKY_EN)
interface seq_div_unit_if #(
  parameter int WIDTH = 24
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_div_zero;
`ifdef DIV_STICKY_EN
  logic             o_sticky;
`endif

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_remainder, o_div_zero
`ifdef DIV_STICKY_EN
    , output o_sticky
`endif
  );

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_remainder, o_div_zero
`ifdef DIV_STICKY_EN
    , input o_sticky
`endif
  );
endinterface

// File: rtl/seq_div_unit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Used for mantissa division in the FP divide path.
// Parameters:
//   WIDTH  operand/quotient/remainder width, 2..32
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      seq_div_unit_if.slave: operand valid/ready in, result valid/ready out
// Optional build macro:
//   DIV_STICKY_EN  adds o_sticky = |remainder, registered with the result
module seq_div_unit #(
  parameter int WIDTH = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  seq_div_unit_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  // Partial remainder always stays below D after an iteration, so WIDTH bits
  // suffice for storage; the WIDTH+1 bit width is only needed for the trial.
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;

  logic             valid_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             div_zero_r;
`ifdef DIV_STICKY_EN
  logic             sticky_r;
`endif

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    shifted = {p, q[WIDTH-1]};
    trial   = shifted - {1'b0, d};
    if (!trial[WIDTH]) begin
      p_next = trial[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      p_next = shifted[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

  assign bus.o_ready     = (state == IDLE);
  assign bus.o_valid     = valid_r;
  assign bus.o_quotient  = quot_r;
  assign bus.o_remainder = rem_r;
  assign bus.o_div_zero  = div_zero_r;
`ifdef DIV_STICKY_EN
  assign bus.o_sticky    = sticky_r;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      count      <= '0;
      p          <= '0;
      q          <= '0;
      d          <= '0;
      valid_r    <= 1'b0;
      quot_r     <= '0;
      rem_r      <= '0;
      div_zero_r <= 1'b0;
`ifdef DIV_STICKY_EN
      sticky_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            d <= bus.i_divisor;
            if (bus.i_divisor == '0) begin
              q     <= '1;
              p     <= bus.i_dividend;
              state <= DONE;
            end else begin
              q     <= bus.i_dividend;
              p     <= '0;
              count <= '0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p     <= p_next;
          q     <= q_next;
          count <= count + 1'b1;
          // Result registers load on the final iteration edge so o_valid
          // rises exactly WIDTH edges after accept.
          if (count == CW'(WIDTH - 1)) begin
            state      <= DONE;
            valid_r    <= 1'b1;
            quot_r     <= q_next;
            rem_r      <= p_next;
            div_zero_r <= 1'b0;
`ifdef DIV_STICKY_EN
            sticky_r   <= |p_next;
`endif
          end
        end
        DONE: begin
          // Only the divide-by-zero path enters DONE with o_valid low; its
          // result is published one edge after accept.
          if (!valid_r) begin
            valid_r    <= 1'b1;
            quot_r     <= q;
            rem_r      <= p;
            div_zero_r <= 1'b1;
`ifdef DIV_STICKY_EN
            sticky_r   <= 1'b0;
`endif
          end else if (bus.i_ready) begin
            valid_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit (WIDTH=24) with a scoreboard of
// expected results pushed at operand accept and popped at result valid.
module tb_seq_div_unit;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  seq_div_unit_if #(.WIDTH(W)) bus ();

  seq_div_unit #(.WIDTH(W)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         st;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
    exp_t e;
    if (d == '0) begin
      e.q = '1; e.r = n; e.dz = 1'b1; e.st = 1'b0; e.lat = 1;
    end else begin
      e.q = n / d; e.r = n % d; e.dz = 1'b0; e.st = (e.r != '0); e.lat = W;
    end
    return e;
  endfunction

  // Waits for o_ready, presents operands for one accept edge, records expectation.
  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d);
    int guard = 0;
    while (!bus.o_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    bus.i_valid = 1'b1;
    bus.i_dividend = n;
    bus.i_divisor = d;
    sb.push_back(model(n, d));
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until o_valid; pops the expectation.
  task automatic collect(input bit scramble, output exp_t e, output int lat);
    lat = 0;
    while (!bus.o_valid && lat < 200) begin
      if (scramble) begin
        bus.i_dividend = W'($urandom);
        bus.i_divisor = W'($urandom);
      end
      @(posedge clk); #1; lat++;
    end
    if (sb.size() == 0) begin
      e = model('0, '0);
      e.lat = -1;
    end else begin
      e = sb.pop_front();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b0;
    bus.i_dividend = '0; bus.i_divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_quotient !== '0 || bus.o_remainder !== '0 || bus.o_div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b q=%h r=%h dz=%0b want all zero",
               bus.o_valid, bus.o_quotient, bus.o_remainder, bus.o_div_zero);
    end
`ifdef DIV_STICKY_EN
    checks++;
    if (bus.o_sticky !== 1'b0) begin
      errors++; $display("FAIL reset_sticky got %0b want 0", bus.o_sticky);
    end
`endif
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %0b want 1", bus.o_ready);
    end
  endtask

  task automatic test_basic;
    exp_t e; int lat;
    bus.i_ready = 1'b1;
    issue(24'd100, 24'd7);
    checks++;
    if (bus.o_ready !== 1'b0) begin
      errors++; $display("FAIL basic_busy got o_ready=%0b want 0", bus.o_ready);
    end
    collect(1'b0, e, lat);
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL basic_latency got %0d want %0d", lat, e.lat);
    end
    checks++;
    if (bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_zero !== e.dz || e.q !== 24'd14 || e.r !== 24'd2) begin
      errors++; $display("FAIL basic_result got q=%h r=%h dz=%0b want q=%h r=%h dz=%0b",
                         bus.o_quotient, bus.o_remainder, bus.o_div_zero, e.q, e.r, e.dz);
    end
`ifdef DIV_STICKY_EN
    checks++;
    if (bus.o_sticky !== e.st) begin
      errors++; $display("FAIL basic_sticky got %0b want %0b", bus.o_sticky, e.st);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_quotient !== e.q || bus.o_remainder !== e.r) begin
      errors++; $display("FAIL basic_idle got v=%0b rdy=%0b q=%h r=%h want v=0 rdy=1 q=%h r=%h",
                         bus.o_valid, bus.o_ready, bus.o_quotient, bus.o_remainder, e.q, e.r);
    end
  endtask

  task automatic test_boundaries;
    logic [W-1:0] ns [3];
    logic [W-1:0] ds [3];
    exp_t e; int lat;
    ns = '{24'hFFFFFF, 24'd5, 24'd0};
    ds = '{24'd1, 24'd9, 24'd3};
    bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ns[i], ds[i]);
      collect(1'b0, e, lat);
      checks++;
      if (lat !== e.lat || bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_zero !== e.dz) begin
        errors++; $display("FAIL boundary_%0d got lat=%0d q=%h r=%h dz=%0b want lat=%0d q=%h r=%h dz=%0b",
                           i, lat, bus.o_quotient, bus.o_remainder, bus.o_div_zero, e.lat, e.q, e.r, e.dz);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero;
    exp_t e; int lat;
    bus.i_ready = 1'b1;
    issue(24'd5, 24'd0);
    collect(1'b0, e, lat);
    checks++;
    if (lat !== 1 || bus.o_quotient !== 24'hFFFFFF || bus.o_remainder !== 24'd5 || bus.o_div_zero !== 1'b1) begin
      errors++; $display("FAIL divzero_result got lat=%0d q=%h r=%h dz=%0b want lat=1 q=ffffff r=000005 dz=1",
                         lat, bus.o_quotient, bus.o_remainder, bus.o_div_zero);
    end
`ifdef DIV_STICKY_EN
    checks++;
    if (bus.o_sticky !== 1'b0) begin
      errors++; $display("FAIL divzero_sticky got %0b want 0", bus.o_sticky);
    end
`endif
    @(posedge clk); #1;
    issue(24'd100, 24'd7);
    collect(1'b0, e, lat);
    checks++;
    if (lat !== e.lat || bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_zero !== 1'b0) begin
      errors++; $display("FAIL divzero_next got lat=%0d q=%h r=%h dz=%0b want lat=%0d q=%h r=%h dz=0",
                         lat, bus.o_quotient, bus.o_remainder, bus.o_div_zero, e.lat, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    exp_t e; int lat;
    bus.i_ready = 1'b0;
    issue(24'hC00000, 24'h800000);
    collect(1'b0, e, lat);
    checks++;
    if (lat !== W || e.q !== 24'd1 || e.r !== 24'h400000) begin
      errors++; $display("FAIL bp_latency got lat=%0d want %0d", lat, W);
    end
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1'b1;
      bus.i_dividend = W'(i + 3);
      bus.i_divisor = W'(i + 1);
      @(posedge clk); #1;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_zero !== e.dz) begin
        errors++; $display("FAIL bp_hold_%0d got v=%0b rdy=%0b q=%h r=%h dz=%0b want v=1 rdy=0 q=%h r=%h dz=%0b",
                           i, bus.o_valid, bus.o_ready, bus.o_quotient, bus.o_remainder, bus.o_div_zero, e.q, e.r, e.dz);
      end
`ifdef DIV_STICKY_EN
      checks++;
      if (bus.o_sticky !== 1'b1) begin
        errors++; $display("FAIL bp_sticky_%0d got %0b want 1", i, bus.o_sticky);
      end
`endif
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%0b rdy=%0b want v=0 rdy=1", bus.o_valid, bus.o_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_quotient !== e.q) begin
      errors++; $display("FAIL bp_single_handshake got v=%0b rdy=%0b q=%h want v=0 rdy=1 q=%h",
                         bus.o_valid, bus.o_ready, bus.o_quotient, e.q);
    end
  endtask

  task automatic test_reset_abort;
    exp_t e; int lat;
    bus.i_ready = 1'b1;
    issue(24'd100, 24'd7);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_quotient !== '0 || bus.o_remainder !== '0 || bus.o_div_zero !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got v=%0b q=%h r=%h dz=%0b want all zero",
                         bus.o_valid, bus.o_quotient, bus.o_remainder, bus.o_div_zero);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL abort_ready got rdy=%0b v=%0b want rdy=1 v=0", bus.o_ready, bus.o_valid);
    end
    issue(24'd49, 24'd7);
    collect(1'b0, e, lat);
    checks++;
    if (lat !== e.lat || bus.o_quotient !== 24'd7 || bus.o_remainder !== 24'd0 || bus.o_div_zero !== 1'b0) begin
      errors++; $display("FAIL abort_next got lat=%0d q=%h r=%h dz=%0b want lat=%0d q=000007 r=000000 dz=0",
                         lat, bus.o_quotient, bus.o_remainder, bus.o_div_zero, e.lat);
    end
`ifdef DIV_STICKY_EN
    checks++;
    if (bus.o_sticky !== 1'b0) begin
      errors++; $display("FAIL abort_sticky got %0b want 0", bus.o_sticky);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change;
    exp_t e; int lat;
    bus.i_ready = 1'b1;
    issue(24'd1000000, 24'd37);
    collect(1'b1, e, lat);
    checks++;
    if (lat !== e.lat || bus.o_quotient !== e.q || bus.o_remainder !== e.r) begin
      errors++; $display("FAIL capture_result got lat=%0d q=%h r=%h want lat=%0d q=%h r=%h",
                         lat, bus.o_quotient, bus.o_remainder, e.lat, e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat;
    logic [W-1:0] n, d;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = W'($urandom);
      d = (i % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom >> $urandom_range(0, 20));
      if (i == 5) d = '0;
      issue(n, d);
      collect(1'b0, e, lat);
      checks++;
      if (lat !== e.lat || bus.o_quotient !== e.q || bus.o_remainder !== e.r || bus.o_div_zero !== e.dz) begin
        errors++; $display("FAIL b2b_%0d n=%h d=%h got lat=%0d q=%h r=%h dz=%0b want lat=%0d q=%h r=%h dz=%0b",
                           i, n, d, lat, bus.o_quotient, bus.o_remainder, bus.o_div_zero, e.lat, e.q, e.r, e.dz);
      end
`ifdef DIV_STICKY_EN
      checks++;
      if (bus.o_sticky !== e.st) begin
        errors++; $display("FAIL b2b_sticky_%0d got %0b want %0b", i, bus.o_sticky, e.st);
      end
`endif
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
    test_operand_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
